// File: rtl/idu_decode_stage.sv
// idu_decode_stage: one-entry decode buffer between IFU and EXU with full RV32I field decode.
// Ports: clk_i/reset_i (async, active-high); IFU side inst_i, pc_i, inst_valid_i, inst_ready_o;
//   flush_i redirect; EXU side dec_valid_o, dec_ready_i and decoded dec_* fields from the buffer.
// Option: define IDU_RVE_EN for RV32E register checking (x16..x31 used -> illegal).
module idu_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic        inst_valid_i,
  output logic        inst_ready_o,
  input  logic        flush_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_pc_o,
  output logic [31:0] dec_inst_o,
  output logic [4:0]  dec_rs1_o,
  output logic [4:0]  dec_rs2_o,
  output logic [4:0]  dec_rd_o,
  output logic [31:0] dec_imm_o,
  output logic [3:0]  dec_opclass_o,
  output logic [2:0]  dec_funct3_o,
  output logic        dec_funct7b5_o,
  output logic        dec_rf_we_o,
  output logic        dec_illegal_o
);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d, pc_q, pc_d;
  logic        accept, base_we, rve_bad;
  logic [3:0]  cls;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
      inst_q  <= NOP_INST;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end
  // Flush wins over everything; inst_ready_o is already low during flush so accept cannot fire.
  always_comb begin
    accept  = inst_valid_i && inst_ready_o;
    state_d = flush_i ? EMPTY : accept ? FULL : dec_ready_i ? EMPTY : state_q;
    inst_d  = flush_i ? NOP_INST : accept ? inst_i : inst_q;
    pc_d    = accept ? pc_i : pc_q;
  end
  always_comb begin
    inst_ready_o = !flush_i && (state_q == EMPTY || dec_ready_i);
    dec_valid_o  = state_q == FULL;
  end
  always_comb begin
    cls = 4'd15;
    if (inst_q[1:0] == 2'b11)
      case (inst_q[6:2])
        5'b01101: cls = 4'd0;
        5'b00101: cls = 4'd1;
        5'b11011: cls = 4'd2;
        5'b11001: cls = 4'd3;
        5'b11000: cls = 4'd4;
        5'b00000: cls = 4'd5;
        5'b01000: cls = 4'd6;
        5'b00100: cls = 4'd7;
        5'b01100: cls = 4'd8;
        5'b11100: cls = 4'd9;
        default:  cls = 4'd15;
      endcase
  end
  always_comb begin
    case (cls)
      4'd0, 4'd1:             dec_imm_o = {inst_q[31:12], 12'b0};
      4'd2:                   dec_imm_o = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
      4'd3, 4'd5, 4'd7, 4'd9: dec_imm_o = {{20{inst_q[31]}}, inst_q[31:20]};
      4'd4:                   dec_imm_o = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
      4'd6:                   dec_imm_o = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
      default:                dec_imm_o = 32'b0;
    endcase
  end
  // CSR ops write rd; ECALL/EBREAK (funct3==0) do not.
  assign base_we = (cls <= 4'd3) || cls == 4'd5 || cls == 4'd7 || cls == 4'd8 ||
                   (cls == 4'd9 && inst_q[14:12] != 3'b0);
`ifdef IDU_RVE_EN
  logic rs1_used, rs2_used;
  // CSR immediate forms (funct3[2]) carry a uimm in the rs1 field, not a register.
  assign rs1_used = (cls >= 4'd3 && cls <= 4'd8) ||
                    (cls == 4'd9 && inst_q[13:12] != 2'b0 && !inst_q[14]);
  assign rs2_used = cls == 4'd4 || cls == 4'd6 || cls == 4'd8;
  assign rve_bad  = (rs1_used && inst_q[19]) || (rs2_used && inst_q[24]) || (base_we && inst_q[11]);
`else
  assign rve_bad = 1'b0;
`endif
  assign dec_pc_o       = pc_q;
  assign dec_inst_o     = inst_q;
  assign dec_rs1_o      = inst_q[19:15];
  assign dec_rs2_o      = inst_q[24:20];
  assign dec_rd_o       = inst_q[11:7];
  assign dec_opclass_o  = cls;
  assign dec_funct3_o   = inst_q[14:12];
  assign dec_funct7b5_o = inst_q[30];
  assign dec_rf_we_o    = base_we && !rve_bad && inst_q[11:7] != 5'b0;
  assign dec_illegal_o  = cls == 4'd15 || rve_bad;
endmodule

// File: tb/tb_idu_decode_stage.sv
// tb_idu_decode_stage: directed and randomized check of idu_decode_stage against a queue-based model.
module tb_idu_decode_stage;
  localparam logic [31:0] RST_PC = 32'h3000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  logic        clk = 0, reset = 1;
  logic [31:0] inst = 0, pc = 0;
  logic        inst_valid = 0, inst_ready, flush = 0, dec_valid, dec_ready = 0;
  logic [31:0] dec_pc, dec_inst, dec_imm;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [3:0]  dec_opclass;
  logic [2:0]  dec_funct3;
  logic        dec_funct7b5, dec_rf_we, dec_illegal;
  int total = 0, bad = 0;
  logic [31:0] q[$];
  logic [31:0] last_inst, last_pc;
  always #5 clk = ~clk;
  idu_decode_stage dut (
    .clk_i(clk), .reset_i(reset), .inst_i(inst), .pc_i(pc), .inst_valid_i(inst_valid),
    .inst_ready_o(inst_ready), .flush_i(flush), .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
    .dec_pc_o(dec_pc), .dec_inst_o(dec_inst), .dec_rs1_o(dec_rs1), .dec_rs2_o(dec_rs2),
    .dec_rd_o(dec_rd), .dec_imm_o(dec_imm), .dec_opclass_o(dec_opclass), .dec_funct3_o(dec_funct3),
    .dec_funct7b5_o(dec_funct7b5), .dec_rf_we_o(dec_rf_we), .dec_illegal_o(dec_illegal)
  );
  typedef struct {
    logic [3:0]  cls;
    logic [31:0] imm;
    logic        we, ill;
  } dec_t;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  // Reference decode: immediates built by left-justifying the fields and arithmetic-shifting back.
  function automatic dec_t ref_dec(input logic [31:0] i);
    dec_t d;
    logic signed [31:0] s;
    logic rs1u, rs2u, rdu;
    case (i[6:0])
      7'h37: d.cls = 0;  7'h17: d.cls = 1;  7'h6f: d.cls = 2;  7'h67: d.cls = 3;
      7'h63: d.cls = 4;  7'h03: d.cls = 5;  7'h23: d.cls = 6;  7'h13: d.cls = 7;
      7'h33: d.cls = 8;  7'h73: d.cls = 9;  default: d.cls = 15;
    endcase
    d.imm = 0;
    if (d.cls == 0 || d.cls == 1) d.imm = i & 32'hffff_f000;
    if (d.cls == 3 || d.cls == 5 || d.cls == 7 || d.cls == 9) begin s = i; d.imm = s >>> 20; end
    if (d.cls == 6) begin s = {i[31:25], i[11:7], 20'b0}; d.imm = s >>> 20; end
    if (d.cls == 4) begin s = {i[31], i[7], i[30:25], i[11:8], 20'b0}; d.imm = s >>> 19; end
    if (d.cls == 2) begin s = {i[31], i[19:12], i[20], i[30:21], 12'b0}; d.imm = s >>> 11; end
    rdu  = d.cls inside {0, 1, 2, 3, 5, 7, 8} || (d.cls == 9 && i[14:12] != 0);
    rs1u = d.cls inside {3, 4, 5, 6, 7, 8} || (d.cls == 9 && i[14:12] inside {1, 2, 3});
    rs2u = d.cls inside {4, 6, 8};
    d.we  = rdu && i[11:7] != 0;
    d.ill = d.cls == 15;
`ifdef IDU_RVE_EN
    if ((rdu && i[11:7] >= 16) || (rs1u && i[19:15] >= 16) || (rs2u && i[24:20] >= 16)) begin
      d.ill = 1;
      d.we  = 0;
    end
`else
    if (rs1u && rs2u && 0) d.ill = 1;
`endif
    return d;
  endfunction
  task automatic check_fields();
    dec_t d = ref_dec(last_inst);
    chk("dec_pc", dec_pc, last_pc);
    chk("dec_inst", dec_inst, last_inst);
    chk("opclass", dec_opclass, d.cls);
    chk("imm", dec_imm, d.imm);
    chk("rf_we", dec_rf_we, d.we);
    chk("illegal", dec_illegal, d.ill);
    chk("rs1", dec_rs1, last_inst[19:15]);
    chk("rs2", dec_rs2, last_inst[24:20]);
    chk("rd", dec_rd, last_inst[11:7]);
    chk("funct3", dec_funct3, last_inst[14:12]);
    chk("funct7b5", dec_funct7b5, last_inst[30]);
  endtask
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] p, input logic rdy, input logic fl);
    logic exp_ready;
    inst_valid = v; inst = ins; pc = p; dec_ready = rdy; flush = fl;
    @(negedge clk);
    exp_ready = !fl && (q.size() == 0 || rdy);
    chk("inst_ready", inst_ready, exp_ready);
    chk("dec_valid", dec_valid, q.size() != 0);
    check_fields();
    if (fl) begin
      q.delete();
      last_inst = NOP;
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (v && exp_ready) begin
        q.push_back(ins);
        last_inst = ins;
        last_pc = p;
      end
    end
    @(posedge clk); #1;
  endtask
  initial begin
    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h00};
    logic [31:0] r;
    logic [6:0] op;
    last_inst = NOP; last_pc = RST_PC;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("t1_valid", dec_valid, 0);
    chk("t1_pc", dec_pc, RST_PC);
    chk("t1_inst", dec_inst, NOP);
    chk("t1_ready", inst_ready, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 32'h00500093, 32'h3000_0000, 1, 0);
    chk("t2_valid", dec_valid, 1);
    chk("t2_opc", dec_opclass, 7);
    chk("t2_rd", dec_rd, 1);
    chk("t2_imm", dec_imm, 5);
    chk("t2_we", dec_rf_we, 1);
    repeat (5) cyc(1, 32'h00a00113, 32'h3000_0004, 0, 0);
    chk("t3_held", dec_inst, 32'h00500093);
    cyc(1, 32'h00a00113, 32'h3000_0004, 1, 0);
    chk("t3_inst", dec_inst, 32'h00a00113);
    cyc(1, 32'hfe000ee3, 32'h3000_0008, 1, 0);
    chk("t4_opc", dec_opclass, 4);
    chk("t4_imm", dec_imm, 32'hffff_fffc);
    cyc(1, 32'h0000006f, 32'h3000_000c, 1, 0);
    chk("t4b_valid", dec_valid, 1);
    chk("t4b_opc", dec_opclass, 2);
    chk("t4b_imm", dec_imm, 0);
    chk("t4b_we", dec_rf_we, 0);
    cyc(1, 32'h00300193, 32'h3000_0010, 1, 1);
    chk("t5_valid", dec_valid, 0);
    chk("t5_inst", dec_inst, NOP);
    chk("t5_pc", dec_pc, 32'h3000_000c);
    cyc(1, 32'h00300193, 32'h3000_0010, 1, 0);
    chk("t5_inst2", dec_inst, 32'h00300193);
    cyc(1, 32'h0000_0000, 32'h3000_0014, 1, 0);
    chk("t6_ill", dec_illegal, 1);
    chk("t6_opc", dec_opclass, 15);
    cyc(1, 32'h01000813, 32'h3000_0018, 1, 0);
`ifdef IDU_RVE_EN
    chk("t6_rve_ill", dec_illegal, 1);
`else
    chk("t6_rd", dec_rd, 16);
    chk("t6_we", dec_rf_we, 1);
`endif
    cyc(1, 32'h00500093, 32'h3000_001c, 0, 0);
    reset = 1;
    #2;
    chk("rst_valid", dec_valid, 0);
    chk("rst_pc", dec_pc, RST_PC);
    chk("rst_inst", dec_inst, NOP);
    q.delete(); last_inst = NOP; last_pc = RST_PC;
    @(posedge clk); #1 reset = 0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      op = ops[$urandom_range(0, 10)];
      if (op == 0) op = r[6:0];
      cyc($urandom_range(0, 3) != 0, {r[31:7], op}, $urandom(), $urandom_range(0, 2) != 0,
          $urandom_range(0, 15) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
